// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle between a command source and alu_cmd_sequencer.
interface alu_cmd_sequencer_if #(
  parameter int N = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic         cmd_load;
  logic [N-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_data;
  logic         rsp_co;
  logic         rsp_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_load, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_co, rsp_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_load, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_co, rsp_zero
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Accumulator sequencer: issues one ALU op per command (a = acc, b = cmd_data), returns result.
// Optional sticky carry flag with clr_sticky/sticky_co ports when ALU_SEQ_STICKY_CO_EN is defined.
module alu_cmd_sequencer #(
  parameter int           N        = 4,
  parameter logic [N-1:0] ACC_INIT = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_cmd_sequencer_if.slave  bus,
  output logic [N-1:0]        alu_a,
  output logic [N-1:0]        alu_b,
  output logic [2:0]          alu_sel,
  input  logic [N-1:0]        alu_s,
  input  logic                alu_co,
`ifdef ALU_SEQ_STICKY_CO_EN
  input  logic                clr_sticky,
  output logic                sticky_co,
`endif
  output logic [N-1:0]        acc_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic [N-1:0] acc_reg, acc_next;
  logic         co_reg, co_next;
  logic [2:0]   sel_reg, sel_next;
  logic [N-1:0] b_reg, b_next;
  logic         load_reg, load_next;
  logic         ready_reg, ready_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= ACC_INIT;
      co_reg    <= 1'b0;
      sel_reg   <= 3'b000;
      b_reg     <= '0;
      load_reg  <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      co_reg    <= co_next;
      sel_reg   <= sel_next;
      b_reg     <= b_next;
      load_reg  <= load_next;
      ready_reg <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    co_next    = co_reg;
    sel_next   = sel_reg;
    b_next     = b_reg;
    load_next  = load_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.cmd_valid && ready_reg) begin
          state_next = EXEC;
          b_next     = bus.cmd_data;
          load_next  = bus.cmd_load;
          // A load bypasses the ALU, so the opcode is left as it was.
          if (!bus.cmd_load) begin
            sel_next = bus.cmd_op;
          end
        end
      end
      EXEC: begin
        state_next = RESP;
        acc_next   = load_reg ? b_reg : alu_s;
        co_next    = load_reg ? 1'b0 : alu_co;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Registered so cmd_ready stays low throughout reset and rises one edge after release.
    ready_next = (state_next == IDLE);
  end

  assign alu_a         = acc_reg;
  assign alu_b         = b_reg;
  assign alu_sel       = sel_reg;
  assign acc_q         = acc_reg;
  assign bus.cmd_ready = ready_reg;
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_data  = acc_reg;
  assign bus.rsp_co    = co_reg;
  assign bus.rsp_zero  = (acc_reg == '0);

`ifdef ALU_SEQ_STICKY_CO_EN
  logic sticky_reg, sticky_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg <= 1'b0;
    end else begin
      sticky_reg <= sticky_next;
    end
  end

  always_comb begin
    sticky_next = sticky_reg;
    if (clr_sticky) begin
      sticky_next = 1'b0;
    end
    // A carry in the same cycle as a clear keeps the flag set.
    if (state_reg == EXEC && !load_reg && alu_co) begin
      sticky_next = 1'b1;
    end
  end

  assign sticky_co = sticky_reg;
`endif

endmodule
